// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry defaults, box palette and cursor FSM states
package vga_pkg;

  localparam int H_MAX_DEFAULT = 640;
  localparam int V_MAX_DEFAULT = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } cursor_state_t;

  // Entry 0 sits in the low byte: E0, 1C, 03, FC, E3, 1F, FF, 92
  localparam logic [63:0] PALETTE = {
    8'h92, 8'hFF, 8'h1F, 8'hE3, 8'hFC, 8'h03, 8'h1C, 8'hE0
  };

  function automatic logic [7:0] palette_color(input logic [2:0] idx);
    return PALETTE[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchroniser plus rise detector for one button
module btn_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 bring the asynchronous level into clk; s3 holds the previous synchronised value
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/cursor_controller.sv
// rtl/cursor_controller.sv - push-button driven box position and colour for the VGA overlay
module cursor_controller
  import vga_pkg::*;
#(
  parameter int H_MAX        = H_MAX_DEFAULT,
  parameter int V_MAX        = V_MAX_DEFAULT,
  parameter int BOX_SIZE     = 32,
  parameter int STEP         = 8,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 50
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  input  logic       btn_center_i,
  output logic [9:0] box_x_o,
  output logic [9:0] box_y_o,
  output logic [7:0] color_o,
  output logic       moved_o
);

  localparam logic [10:0] X_LIM     = 11'(H_MAX - BOX_SIZE);
  localparam logic [10:0] Y_LIM     = 11'(V_MAX - BOX_SIZE);
  localparam logic [9:0]  X_RST     = 10'((H_MAX - BOX_SIZE) / 2);
  localparam logic [9:0]  Y_RST     = 10'((V_MAX - BOX_SIZE) / 2);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [9:0]  DELAY_LIM = 10'(REPEAT_DELAY - 1);
  localparam logic [9:0]  RATE_LIM  = 10'(REPEAT_RATE - 1);

  // Button order: 0 up, 1 down, 2 left, 3 right, 4 centre
  logic [4:0] btn_raw;
  logic [4:0] lvl;
  logic [4:0] rise;

  assign btn_raw = {btn_center_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_sync_edge u_sync (
      .clk    (clk_i),
      .resetn (reset_i),
      .btn    (btn_raw[i]),
      .level  (lvl[i]),
      .rise   (rise[i])
    );
  end

  cursor_state_t state_q;
  cursor_state_t state_d;
  logic [9:0]    cnt_q;
  logic [9:0]    box_x_q;
  logic [9:0]    box_y_q;
  logic [2:0]    pal_idx_q;
  logic          moved_q;

  logic step_en;
  logic cnt_clr;
  logic cnt_inc;

  logic any_rise;
  logic any_level;
  logic at_limit;
  logic center_press;

  assign any_rise     = |rise[3:0];
  assign any_level    = |lvl[3:0];
  assign at_limit     = (cnt_q == ((state_q == REPEAT) ? RATE_LIM : DELAY_LIM));
  assign center_press = rise[4] & lvl[4];

  // Opposing buttons cancel on their axis; diagonals move both axes at once
  logic x_inc_en;
  logic x_dec_en;
  logic y_inc_en;
  logic y_dec_en;

  assign x_inc_en = lvl[3] & ~lvl[2];
  assign x_dec_en = lvl[2] & ~lvl[3];
  assign y_inc_en = lvl[1] & ~lvl[0];
  assign y_dec_en = lvl[0] & ~lvl[1];

  // One extra bit lets the subtraction show underflow in bit 10 instead of wrapping
  logic [10:0] x_up;
  logic [10:0] x_dn;
  logic [10:0] y_up;
  logic [10:0] y_dn;
  logic [9:0]  x_next;
  logic [9:0]  y_next;

  assign x_up = {1'b0, box_x_q} + STEP_W;
  assign x_dn = {1'b0, box_x_q} - STEP_W;
  assign y_up = {1'b0, box_y_q} + STEP_W;
  assign y_dn = {1'b0, box_y_q} - STEP_W;

  // Candidate position for a step, saturated at both screen edges
  always_comb begin
    x_next = box_x_q;
    y_next = box_y_q;
    if (x_inc_en) begin
      x_next = (x_up > X_LIM) ? X_LIM[9:0] : x_up[9:0];
    end else if (x_dec_en) begin
      x_next = x_dn[10] ? 10'd0 : x_dn[9:0];
    end
    if (y_inc_en) begin
      y_next = (y_up > Y_LIM) ? Y_LIM[9:0] : y_up[9:0];
    end else if (y_dec_en) begin
      y_next = y_dn[10] ? 10'd0 : y_dn[9:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a fresh press always restarts the hold delay
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_rise) state_d = HOLD;
      end
      HOLD, REPEAT: begin
        if (!any_level)              state_d = IDLE;
        else if (any_rise)           state_d = HOLD;
        else if (tick_i && at_limit) state_d = REPEAT;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: when to step and how to drive the tick counter
  always_comb begin
    step_en = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_rise) begin
          step_en = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      HOLD, REPEAT: begin
        if (!any_level) begin
          cnt_clr = 1'b1;
        end else if (any_rise) begin
          step_en = 1'b1;
          cnt_clr = 1'b1;
        end else if (tick_i) begin
          if (at_limit) begin
            step_en = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Position, move pulse, tick counter and palette index
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      box_x_q   <= X_RST;
      box_y_q   <= Y_RST;
      moved_q   <= 1'b0;
      cnt_q     <= 10'd0;
      pal_idx_q <= 3'd0;
    end else begin
      moved_q <= step_en && ((x_next != box_x_q) || (y_next != box_y_q));
      if (step_en) begin
        box_x_q <= x_next;
        box_y_q <= y_next;
      end
      if (cnt_clr) begin
        cnt_q <= 10'd0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 10'd1;
      end
      if (center_press) begin
        pal_idx_q <= pal_idx_q + 3'd1;
      end
    end
  end

  assign box_x_o = box_x_q;
  assign box_y_o = box_y_q;
  assign color_o = palette_color(pal_idx_q);
  assign moved_o = moved_q;

endmodule

// File: tb/tb_cursor_controller.sv
// tb/tb_cursor_controller.sv - scoreboard bench for cursor_controller
module tb_cursor_controller;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       tick_i = 1'b0;
  logic       btn_up_i = 1'b0;
  logic       btn_down_i = 1'b0;
  logic       btn_left_i = 1'b0;
  logic       btn_right_i = 1'b0;
  logic       btn_center_i = 1'b0;
  logic [9:0] box_x_o;
  logic [9:0] box_y_o;
  logic [7:0] color_o;
  logic       moved_o;

  always #5 clk = ~clk;

  cursor_controller dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .tick_i       (tick_i),
    .btn_up_i     (btn_up_i),
    .btn_down_i   (btn_down_i),
    .btn_left_i   (btn_left_i),
    .btn_right_i  (btn_right_i),
    .btn_center_i (btn_center_i),
    .box_x_o      (box_x_o),
    .box_y_o      (box_y_o),
    .color_o      (color_o),
    .moved_o      (moved_o)
  );

  int checks = 0;
  int errors = 0;

  logic [19:0] pos_q[$];
  logic [7:0]  col_q[$];
  logic        mon_en = 1'b0;
  logic [7:0]  prev_color = 8'h00;
  logic [19:0] exp_pos;
  logic [7:0]  exp_col;
  int          moved_count = 0;

  int mx;
  int my;
  int pidx;
  logic [7:0] pal_ref [8] = '{8'hE0, 8'h1C, 8'h03, 8'hFC, 8'hE3, 8'h1F, 8'hFF, 8'h92};

  // Scoreboard: each moved_o pulse and each colour change pops one expectation
  always @(negedge clk) begin
    if (mon_en) begin
      if (moved_o === 1'b1) begin
        moved_count++;
        checks++;
        if (pos_q.size() == 0) begin
          errors++;
          $display("FAIL moved_unexpected got x=%0d y=%0d expected no move", box_x_o, box_y_o);
        end else begin
          exp_pos = pos_q.pop_front();
          if ({box_x_o, box_y_o} !== exp_pos) begin
            errors++;
            $display("FAIL moved_position got x=%0d y=%0d expected x=%0d y=%0d",
                     box_x_o, box_y_o, exp_pos[19:10], exp_pos[9:0]);
          end
        end
      end
      if (color_o !== prev_color) begin
        checks++;
        if (col_q.size() == 0) begin
          errors++;
          $display("FAIL color_unexpected got %h expected %h", color_o, prev_color);
        end else begin
          exp_col = col_q.pop_front();
          if (color_o !== exp_col) begin
            errors++;
            $display("FAIL color_value got %h expected %h", color_o, exp_col);
          end
        end
      end
    end
    prev_color = color_o;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_i = 1'b1;
      @(posedge clk);
      #1;
      tick_i = 1'b0;
      idle_cycles(3);
    end
  endtask

  task automatic model_step(input int dx, input int dy);
    int nx;
    int ny;
    nx = mx + 8 * dx;
    ny = my + 8 * dy;
    if (nx > 608) nx = 608;
    if (nx < 0)   nx = 0;
    if (ny > 448) ny = 448;
    if (ny < 0)   ny = 0;
    if (nx != mx || ny != my) pos_q.push_back({10'(nx), 10'(ny)});
    mx = nx;
    my = ny;
  endtask

  task automatic set_dirs(input logic u, input logic d, input logic l, input logic r);
    btn_up_i    = u;
    btn_down_i  = d;
    btn_left_i  = l;
    btn_right_i = r;
  endtask

  // Press, sit through the hold delay, then n_rep auto-repeat steps, then release
  task automatic hold_dir(input logic u, input logic d, input logic l, input logic r, input int n_rep);
    int dx;
    int dy;
    dx = int'(r) - int'(l);
    dy = int'(d) - int'(u);
    model_step(dx, dy);
    set_dirs(u, d, l, r);
    idle_cycles(4);
    ticks(399);
    model_step(dx, dy);
    ticks(1);
    for (int k = 0; k < n_rep; k++) begin
      ticks(49);
      model_step(dx, dy);
      ticks(1);
    end
    set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(5);
  endtask

  task automatic test_reset;
    mon_en  = 1'b0;
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if (box_x_o !== 10'd304) begin errors++; $display("FAIL reset_x got %0d expected 304", box_x_o); end
    checks++;
    if (box_y_o !== 10'd224) begin errors++; $display("FAIL reset_y got %0d expected 224", box_y_o); end
    checks++;
    if (color_o !== 8'hE0) begin errors++; $display("FAIL reset_color got %h expected e0", color_o); end
    checks++;
    if (moved_o !== 1'b0) begin errors++; $display("FAIL reset_moved got %b expected 0", moved_o); end
    mx   = 304;
    my   = 224;
    pidx = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic test_single_step;
    int m0;
    m0 = moved_count;
    model_step(1, 0);
    btn_right_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (box_x_o !== 10'd304) begin errors++; $display("FAIL latency_early got %0d expected 304", box_x_o); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (box_x_o !== 10'd312) begin errors++; $display("FAIL latency_third_edge got %0d expected 312", box_x_o); end
    @(posedge clk);
    #1;
    idle_cycles(96);
    btn_right_i = 1'b0;
    idle_cycles(5);
    checks++;
    if (box_x_o !== 10'd312) begin errors++; $display("FAIL single_step_x got %0d expected 312", box_x_o); end
    checks++;
    if (moved_count - m0 !== 1) begin errors++; $display("FAIL single_step_pulses got %0d expected 1", moved_count - m0); end
    checks++;
    if (pos_q.size() != 0) begin errors++; $display("FAIL single_step_missing got %0d pending expected 0", pos_q.size()); end
  endtask

  task automatic test_auto_repeat;
    hold_dir(1'b0, 1'b1, 1'b0, 1'b0, 3);
    checks++;
    if (box_y_o !== 10'd264) begin errors++; $display("FAIL auto_repeat_y got %0d expected 264", box_y_o); end
    checks++;
    if (pos_q.size() != 0) begin errors++; $display("FAIL auto_repeat_missing got %0d pending expected 0", pos_q.size()); end
  endtask

  task automatic test_saturation;
    int m0;
    m0 = moved_count;
    hold_dir(1'b0, 1'b0, 1'b0, 1'b1, 45);
    checks++;
    if (box_x_o !== 10'd608) begin errors++; $display("FAIL sat_right_x got %0d expected 608", box_x_o); end
    checks++;
    if (moved_count - m0 !== 37) begin errors++; $display("FAIL sat_right_pulses got %0d expected 37", moved_count - m0); end
    m0 = moved_count;
    hold_dir(1'b0, 1'b0, 1'b1, 1'b0, 84);
    checks++;
    if (box_x_o !== 10'd0) begin errors++; $display("FAIL sat_left_x got %0d expected 0", box_x_o); end
    checks++;
    if (moved_count - m0 !== 76) begin errors++; $display("FAIL sat_left_pulses got %0d expected 76", moved_count - m0); end
    checks++;
    if (pos_q.size() != 0) begin errors++; $display("FAIL sat_missing got %0d pending expected 0", pos_q.size()); end
  endtask

  task automatic test_opposing;
    int m0;
    m0 = moved_count;
    model_step(0, 0);
    set_dirs(1'b1, 1'b1, 1'b0, 1'b0);
    idle_cycles(10);
    checks++;
    if (box_y_o !== 10'd264) begin errors++; $display("FAIL opposing_y got %0d expected 264", box_y_o); end
    checks++;
    if (moved_count - m0 !== 0) begin errors++; $display("FAIL opposing_pulses got %0d expected 0", moved_count - m0); end
    set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(5);
    model_step(1, -1);
    set_dirs(1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycles(6);
    checks++;
    if ({box_x_o, box_y_o} !== {10'd8, 10'd256}) begin
      errors++;
      $display("FAIL diagonal got x=%0d y=%0d expected x=8 y=256", box_x_o, box_y_o);
    end
    set_dirs(1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycles(5);
  endtask

  task automatic test_colour;
    for (int i = 0; i < 9; i++) begin
      pidx = (pidx + 1) % 8;
      col_q.push_back(pal_ref[pidx]);
      btn_center_i = 1'b1;
      idle_cycles(5);
      btn_center_i = 1'b0;
      idle_cycles(5);
    end
    checks++;
    if (color_o !== 8'h1C) begin errors++; $display("FAIL colour_wrap got %h expected 1c", color_o); end
    pidx = (pidx + 1) % 8;
    col_q.push_back(pal_ref[pidx]);
    model_step(1, 0);
    btn_center_i = 1'b1;
    btn_right_i  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (color_o !== 8'h03 || box_x_o !== 10'd16) begin
      errors++;
      $display("FAIL colour_and_move got color=%h x=%0d expected color=03 x=16", color_o, box_x_o);
    end
    @(posedge clk);
    #1;
    btn_center_i = 1'b0;
    btn_right_i  = 1'b0;
    idle_cycles(5);
    checks++;
    if (col_q.size() != 0 || pos_q.size() != 0) begin
      errors++;
      $display("FAIL colour_missing got %0d/%0d pending expected 0/0", col_q.size(), pos_q.size());
    end
  endtask

  task automatic test_reset_mid_hold;
    model_step(-1, 0);
    btn_left_i = 1'b1;
    idle_cycles(4);
    ticks(399);
    model_step(-1, 0);
    ticks(1);
    ticks(2);
    checks++;
    if (box_x_o !== 10'd0 || pos_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset got x=%0d pending=%0d expected x=0 pending=0", box_x_o, pos_q.size());
    end
    mon_en  = 1'b0;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({box_x_o, box_y_o} !== {10'd304, 10'd224} || moved_o !== 1'b0 || color_o !== 8'hE0) begin
      errors++;
      $display("FAIL mid_reset got x=%0d y=%0d moved=%b color=%h expected x=304 y=224 moved=0 color=e0",
               box_x_o, box_y_o, moved_o, color_o);
    end
    mx   = 304;
    my   = 224;
    pidx = 0;
    @(posedge clk);
    #1;
    model_step(-1, 0);
    mon_en = 1'b1;
    idle_cycles(5);
    checks++;
    if (box_x_o !== 10'd296) begin errors++; $display("FAIL post_reset_step got %0d expected 296", box_x_o); end
    ticks(399);
    checks++;
    if (box_x_o !== 10'd296) begin errors++; $display("FAIL post_reset_hold got %0d expected 296", box_x_o); end
    model_step(-1, 0);
    ticks(1);
    checks++;
    if (box_x_o !== 10'd288) begin errors++; $display("FAIL post_reset_repeat got %0d expected 288", box_x_o); end
    btn_left_i = 1'b0;
    idle_cycles(5);
    checks++;
    if (pos_q.size() != 0 || col_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_missing got %0d/%0d pending expected 0/0", pos_q.size(), col_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_auto_repeat();
    test_saturation();
    test_opposing();
    test_colour();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
